// File: rtl/block_tiler_if.sv
// block_tiler_if: pixel-in / tile-out handshake bundle for block_tiler.
// The master modport is the tiler side; the slave modport is the pixel producer and tile consumer.
interface block_tiler_if #(
   parameter int N     = 16,
   parameter int BLK   = 8,
   parameter int IMG_W = 128,
   parameter int IMG_H = 128
);
   localparam int TC = IMG_W / BLK;
   localparam int TR = IMG_H / BLK;
   localparam int CW = (TC > 1) ? $clog2(TC) : 1;
   localparam int RW = (TR > 1) ? $clog2(TR) : 1;

   logic signed [N-1:0]     pix_in;
   logic                    pix_valid;
   logic                    pix_ready;
   logic [N*BLK*BLK-1:0]    blk_data;
   logic                    blk_valid;
   logic                    blk_ready;
   logic [RW-1:0]           blk_row;
   logic [CW-1:0]           blk_col;
   logic                    frame_done;

   modport master (
      input  pix_in, pix_valid, blk_ready,
      output pix_ready, blk_data, blk_valid, blk_row, blk_col, frame_done
   );

   modport slave (
      output pix_in, pix_valid, blk_ready,
      input  pix_ready, blk_data, blk_valid, blk_row, blk_col, frame_done
   );
endinterface

// File: rtl/block_tiler.sv
// block_tiler: buffers BLK raster rows and emits BLK x BLK tiles packed as dct2d data_in.
// Define BLOCK_TILER_PINGPONG_EN for two strip buffers so filling overlaps draining.
module block_tiler #(
   parameter int N     = 16,
   parameter int BLK   = 8,
   parameter int IMG_W = 128,
   parameter int IMG_H = 128
) (
   input logic           clk,
   input logic           rst_n,
   block_tiler_if.master bus
);
   localparam int TC = IMG_W / BLK;
   localparam int TR = IMG_H / BLK;
   localparam int CW = (TC > 1) ? $clog2(TC) : 1;
   localparam int RW = (TR > 1) ? $clog2(TR) : 1;
   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (BLK > 1) ? $clog2(BLK) : 1;
   localparam int TW = N * BLK * BLK;

   localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YLAST = YW'(BLK - 1);
   localparam logic [CW-1:0] CLAST = CW'(TC - 1);
   localparam logic [RW-1:0] RLAST = RW'(TR - 1);

   typedef logic signed [N-1:0] strip_t [BLK][IMG_W];

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          acc;
   logic          last_acc;
   logic [TW-1:0] first_tile;
   logic [TW-1:0] tile_p0;
   logic          vld_p0;
   logic [RW-1:0] row_p0;
   logic [CW-1:0] col_p0;
   logic          done_p0;

   // Element (r,c) of tile column tc lands at slice BLK*BLK-1-(r*BLK+c).
   function automatic logic [TW-1:0] pack_tile(input strip_t s, input logic [CW-1:0] tc);
      logic [TW-1:0] t;
      t = '0;
      for (int r = 0; r < BLK; r++)
         for (int k = 0; k < BLK; k++)
            t[(BLK*BLK-1-(r*BLK+k))*N +: N] = s[r][int'(tc)*BLK+k];
      return t;
   endfunction

   assign acc      = bus.pix_valid && bus.pix_ready;
   assign last_acc = acc && (y == YLAST) && (x == XLAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (acc) begin
         if (x == XLAST) begin
            x <= '0;
            y <= (y == YLAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

`ifdef BLOCK_TILER_PINGPONG_EN
   strip_t     sbuf [2];
   logic       fsel;
   logic       dsel;
   logic [1:0] full;
   logic       run_p0;
   logic       load_now;

   always_ff @(posedge clk) begin
      if (acc) sbuf[fsel][y][x] <= bus.pix_in;
   end

   // Only the strip completing this cycle can be loaded while its last pixel is in flight.
   always_comb begin
      first_tile = pack_tile(sbuf[dsel], '0);
      if (TC == 1 && last_acc && fsel == dsel) first_tile[N-1:0] = bus.pix_in;
   end

   assign load_now      = !vld_p0 && (full[dsel] || (last_acc && fsel == dsel));
   assign bus.pix_ready = run_p0 && !full[fsel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_p0  <= 1'b0;
         fsel    <= 1'b0;
         dsel    <= 1'b0;
         full    <= '0;
         vld_p0  <= 1'b0;
         tile_p0 <= '0;
         row_p0  <= '0;
         col_p0  <= '0;
         done_p0 <= 1'b0;
      end else begin
         run_p0  <= 1'b1;
         done_p0 <= 1'b0;
         if (last_acc) begin
            full[fsel] <= 1'b1;
            fsel       <= ~fsel;
         end
         if (load_now) begin
            vld_p0  <= 1'b1;
            tile_p0 <= first_tile;
            col_p0  <= '0;
         end else if (vld_p0 && bus.blk_ready) begin
            if (col_p0 == CLAST) begin
               vld_p0     <= 1'b0;
               full[dsel] <= 1'b0;
               dsel       <= ~dsel;
               col_p0     <= '0;
               row_p0     <= (row_p0 == RLAST) ? '0 : row_p0 + 1'b1;
               done_p0    <= (row_p0 == RLAST);
            end else begin
               col_p0  <= col_p0 + 1'b1;
               tile_p0 <= pack_tile(sbuf[dsel], col_p0 + 1'b1);
            end
         end
      end
   end
`else
   typedef enum logic {FILL, DRAIN} state_t;

   strip_t sbuf;
   state_t state;
   logic   rdy_p0;

   always_ff @(posedge clk) begin
      if (acc) sbuf[y][x] <= bus.pix_in;
   end

   // With a single tile column the closing pixel belongs to the tile being loaded.
   always_comb begin
      first_tile = pack_tile(sbuf, '0);
      if (TC == 1) first_tile[N-1:0] = bus.pix_in;
   end

   assign bus.pix_ready = rdy_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FILL;
         rdy_p0  <= 1'b0;
         vld_p0  <= 1'b0;
         tile_p0 <= '0;
         row_p0  <= '0;
         col_p0  <= '0;
         done_p0 <= 1'b0;
      end else begin
         done_p0 <= 1'b0;
         case (state)
            FILL: begin
               rdy_p0 <= !last_acc;
               if (last_acc) begin
                  state   <= DRAIN;
                  vld_p0  <= 1'b1;
                  tile_p0 <= first_tile;
                  col_p0  <= '0;
               end
            end
            DRAIN: begin
               if (bus.blk_ready) begin
                  if (col_p0 == CLAST) begin
                     state   <= FILL;
                     rdy_p0  <= 1'b1;
                     vld_p0  <= 1'b0;
                     col_p0  <= '0;
                     row_p0  <= (row_p0 == RLAST) ? '0 : row_p0 + 1'b1;
                     done_p0 <= (row_p0 == RLAST);
                  end else begin
                     col_p0  <= col_p0 + 1'b1;
                     tile_p0 <= pack_tile(sbuf, col_p0 + 1'b1);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end
`endif

   assign bus.blk_valid  = vld_p0;
   assign bus.blk_data   = tile_p0;
   assign bus.blk_row    = row_p0;
   assign bus.blk_col    = col_p0;
   assign bus.frame_done = done_p0;
endmodule

// File: tb/tb_block_tiler.sv
// tb_block_tiler: randomized raster stimulus against a frame-level tile model for block_tiler.
// Build with +define+BLOCK_TILER_PINGPONG_EN to exercise the two-buffer variant.
module tb_block_tiler;
   localparam int N     = 16;
   localparam int BLK   = 8;
   localparam int IMG_W = 16;
   localparam int IMG_H = 16;
   localparam int TC    = IMG_W / BLK;
   localparam int TR    = IMG_H / BLK;
   localparam int TW    = N * BLK * BLK;
   localparam int CKW   = N * BLK;
   localparam int NPIX  = IMG_W * IMG_H;

   typedef struct {
      logic [TW-1:0] d;
      int            r;
      int            c;
   } tile_t;

   logic clk;
   logic rst_n;

   block_tiler_if #(.N(N), .BLK(BLK), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

   block_tiler #(.N(N), .BLK(BLK), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            checks   = 0;
   int            errors   = 0;
   int            fd_count = 0;
   int            mx       = 0;
   int            my       = 0;
   bit            done_due = 0;
   bit            prev_stall = 0;
   bit            pp_watch = 0;
   bit            rdy_mode = 0;
   logic [TW-1:0] prev_data;
   int            prev_row;
   int            prev_col;
   logic [N-1:0]  src  [NPIX];
   logic [N-1:0]  mimg [IMG_H][IMG_W];
   logic [TW-1:0] got  [TR*TC];
   tile_t         expq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-frame image; a finished strip yields TC tiles cut with plain index math.
   initial begin
      tile_t         e;
      logic [TW-1:0] t;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expq.delete();
            mx = 0; my = 0; done_due = 0; prev_stall = 0;
         end else begin
            if (done_due || bus.frame_done) chk("frame_done", bus.frame_done, done_due);
            if (bus.frame_done) fd_count++;
            done_due = 0;
            if (prev_stall) begin
               chk("hold_valid", bus.blk_valid, 1);
               chk("hold_data", bus.blk_data == prev_data, 1);
               chk("hold_row", bus.blk_row, prev_row);
               chk("hold_col", bus.blk_col, prev_col);
            end
            if (pp_watch) chk("pp_pix_ready", bus.pix_ready, 1);
            if (bus.blk_valid && bus.blk_ready) begin
               chk("tile_expected", expq.size() > 0, 1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  for (int r = 0; r < BLK; r++)
                     chk($sformatf("tile_r%0d_c%0d_line%0d", e.r, e.c, r),
                         bus.blk_data[TW-1-r*CKW -: CKW], e.d[TW-1-r*CKW -: CKW]);
                  chk("blk_row", bus.blk_row, e.r);
                  chk("blk_col", bus.blk_col, e.c);
                  got[e.r*TC+e.c] = bus.blk_data;
                  if (e.r == TR-1 && e.c == TC-1) done_due = 1;
`ifndef BLOCK_TILER_PINGPONG_EN
                  chk("drain_pix_ready", bus.pix_ready, 0);
`endif
               end
            end
            prev_stall = bus.blk_valid && !bus.blk_ready;
            prev_data  = bus.blk_data;
            prev_row   = int'(bus.blk_row);
            prev_col   = int'(bus.blk_col);
            if (bus.pix_valid && bus.pix_ready) begin
               mimg[my][mx] = bus.pix_in;
               if (mx == IMG_W-1) begin
                  mx = 0;
                  if (my % BLK == BLK-1) begin
                     for (int c = 0; c < TC; c++) begin
                        t = '0;
                        for (int r = 0; r < BLK; r++)
                           for (int k = 0; k < BLK; k++)
                              t[(BLK*BLK-1-(r*BLK+k))*N +: N] = mimg[(my/BLK)*BLK+r][c*BLK+k];
                        expq.push_back(tile_t'{d: t, r: my/BLK, c: c});
                     end
                  end
                  my = (my + 1) % IMG_H;
               end else begin
                  mx++;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rdy_mode) bus.blk_ready = ($urandom_range(0, 99) < 60);
      end
   end

   task automatic drive_pixels(input int count, input int gap_pct, input int budget);
      int idx = 0;
      int cyc = 0;
      bit took;
      while (idx < count && cyc < budget) begin
         bus.pix_valid = ($urandom_range(0, 99) >= gap_pct);
         bus.pix_in    = src[idx % NPIX];
         @(negedge clk);
         took = bus.pix_valid && bus.pix_ready;
         @(posedge clk); #1;
         if (took) idx++;
         cyc++;
      end
      bus.pix_valid = 1'b0;
      chk("pixels_driven", idx, count);
   endtask

   task automatic wait_drain(input int budget);
      int w = 0;
      while ((expq.size() != 0 || bus.blk_valid) && w < budget) begin
         @(posedge clk); #1;
         w++;
      end
      chk("drain_queue", expq.size(), 0);
      chk("drain_valid", bus.blk_valid, 0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic set_pattern();
      for (int i = 0; i < NPIX; i++) src[i] = N'((i / IMG_W) * 16 + (i % IMG_W));
   endtask

   task automatic check_reset_zero();
      chk("rst_pix_ready", bus.pix_ready, 0);
      chk("rst_blk_valid", bus.blk_valid, 0);
      chk("rst_blk_data", bus.blk_data == '0, 1);
      chk("rst_blk_row", bus.blk_row, 0);
      chk("rst_blk_col", bus.blk_col, 0);
      chk("rst_frame_done", bus.frame_done, 0);
   endtask

   task automatic check_release();
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_pix_ready", bus.pix_ready, 1);
      chk("post_rst_blk_valid", bus.blk_valid, 0);
      @(posedge clk); #1;
   endtask

   task automatic check_pattern_tiles();
      logic [TW-1:0] g;
      g = got[1];
      chk("t01_msb", g[TW-1 -: N], 8);
      chk("t01_lsb", g[N-1:0], 127);
      g = got[3];
      chk("t11_msb", g[TW-1 -: N], 136);
      chk("t11_lsb", g[N-1:0], 255);
   endtask

   initial begin
      logic [TW-1:0] g;
      rst_n         = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_in    = 16'sh1234;
      bus.blk_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_zero();
      check_release();

      // Plain frame, consumer always ready.
      set_pattern();
      drive_pixels(NPIX, 0, 4000);
      wait_drain(200);
      check_pattern_tiles();
      chk("frames_a", fd_count, 1);

      // Consumer stalls on the first tile.
      bus.blk_ready = 1'b0;
      fork
         drive_pixels(NPIX, 0, 4000);
         begin : bp_ctl
            int w;
            w = 0;
            while (!bus.blk_valid && w < 2000) begin @(negedge clk); w++; end
            chk("bp_tile_seen", bus.blk_valid, 1);
            repeat (5) begin
               @(negedge clk);
               chk("bp_valid", bus.blk_valid, 1);
               chk("bp_row", bus.blk_row, 0);
               chk("bp_col", bus.blk_col, 0);
`ifndef BLOCK_TILER_PINGPONG_EN
               chk("bp_pix_ready", bus.pix_ready, 0);
`endif
            end
            @(posedge clk); #1;
            bus.blk_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("bp_next_valid", bus.blk_valid, 1);
            chk("bp_next_col", bus.blk_col, 1);
         end
      join
      wait_drain(200);
      chk("frames_bp", fd_count, 2);

      // Same frame with input gaps.
      drive_pixels(NPIX, 50, 4000);
      wait_drain(200);
      check_pattern_tiles();
      chk("frames_gap", fd_count, 3);

      // Random pixels, random gaps, random consumer stalls.
      for (int i = 0; i < NPIX; i++) src[i] = N'($urandom);
      rdy_mode = 1;
      drive_pixels(NPIX, 30, 6000);
      wait_drain(2000);
      rdy_mode = 0;
      bus.blk_ready = 1'b1;
      chk("frames_rand", fd_count, 4);

      // Abort a strip with reset, then a clean frame.
      set_pattern();
      for (int i = 0; i < 40; i++) src[i] = N'(16'h7000 + i);
      drive_pixels(40, 0, 400);
      rst_n = 1'b0;
      bus.pix_valid = 1'b1;
      @(negedge clk);
      check_reset_zero();
      check_release();
      set_pattern();
      drive_pixels(NPIX, 0, 4000);
      wait_drain(200);
      g = got[0];
      chk("rst_t00_msb", g[TW-1 -: N], 0);
      chk("rst_t00_lsb", g[N-1:0], 119);
      chk("frames_rst", fd_count, 5);

`ifdef BLOCK_TILER_PINGPONG_EN
      // Two back-to-back frames: input must never stall.
      pp_watch = 1;
      drive_pixels(2*NPIX, 0, 2*NPIX+10);
      pp_watch = 0;
      wait_drain(200);
      chk("frames_pp", fd_count, 7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
